// File: rtl/fp32_sum_reducer_if.sv
// Bus bundle for fp32_sum_reducer: the element stream (valid/ready/last), the
// operand-pair issue port towards Adder_fp32, the adder result return port and
// the sum/status outputs.
//   slave  : the reducer's view (consumes elements and adder results, drives the rest)
//   master : the environment's view (element source, adder, sum sink)
interface fp32_sum_reducer_if;
  logic        i_data_valid;
  logic        i_data_ready;
  logic [31:0] i_data;
  logic        i_data_last;
  logic        o_add_valid;
  logic [31:0] o_add_data1;
  logic [31:0] o_add_data2;
  logic        i_add_valid;
  logic [31:0] i_add_data;
  logic        o_sum_valid;
  logic [31:0] o_sum;
  logic        o_busy;
  logic        o_err;

  modport slave (
    input  i_data_valid, i_data, i_data_last, i_add_valid, i_add_data,
    output i_data_ready, o_add_valid, o_add_data1, o_add_data2,
           o_sum_valid, o_sum, o_busy, o_err
  );

  modport master (
    output i_data_valid, i_data, i_data_last, i_add_valid, i_add_data,
    input  i_data_ready, o_add_valid, o_add_data1, o_add_data2,
           o_sum_valid, o_sum, o_busy, o_err
  );
endinterface

// File: rtl/fp32_sum_reducer.sv
// fp32_sum_reducer: sequencer in front of a fixed-latency fp32 adder that
// reduces one fp32 vector (valid/ready stream terminated by last) to its sum.
// Elements and returned partial sums are paired up and issued to the adder one
// pair per cycle; results come back into a small FIFO and are re-paired until a
// single value remains, which is presented as a one-cycle o_sum_valid pulse.
// Ports:
//   s_clk, s_rst : clock (rising edge), synchronous active-high reset
//   bus.i_data_* : element stream in (valid/ready/last)
//   bus.o_add_*  : operand pair out to the adder (no backpressure)
//   bus.i_add_*  : adder result in
//   bus.o_sum*   : vector sum pulse; o_busy while a vector is in progress
//   bus.o_err    : sticky flag for an adder result nobody was waiting for
module fp32_sum_reducer #(
  parameter int ADD_LATENCY = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic              s_clk,
  input  logic              s_rst,
  fp32_sum_reducer_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam int GRD_W = ($clog2(ADD_LATENCY + 1) > 0) ? $clog2(ADD_LATENCY + 1) : 1;

  typedef enum logic {ST_ACCUM, ST_DRAIN} state_t;

  state_t             state_q, state_d;
  logic               h_full_q, h_full_d;
  logic [31:0]        h_data_q, h_data_d;
  logic [31:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   p_count_q, p_count_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [GRD_W-1:0]   guard_q, guard_d;
  logic               add_valid_q, add_valid_d;
  logic [31:0]        add_data1_q, add_data1_d;
  logic [31:0]        add_data2_q, add_data2_d;
  logic               sum_valid_q, sum_valid_d;
  logic [31:0]        sum_q, sum_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               p_nonempty;
  logic [31:0]        p_head;
  logic [OCC_W-1:0]   occupancy;
  logic               ready;
  logic               take_x;
  logic               res_take;
  logic               res_bad;
  logic               issue;
  logic               pop;

  // Occupancy counts FIFO entries plus results still in the adder: every
  // outstanding result is guaranteed a FIFO slot, so the FIFO never overflows.
  assign p_nonempty = (p_count_q != '0);
  assign p_head     = fifo_mem_q[rd_ptr_q];
  assign occupancy  = {1'b0, p_count_q} + {1'b0, inflight_q};
  assign ready      = (state_q == ST_ACCUM) && !(h_full_q && p_nonempty) &&
                      (occupancy < OCC_W'(FIFO_DEPTH));
  assign take_x     = bus.i_data_valid && ready;
  assign res_take   = bus.i_add_valid && (inflight_q != '0);
  // Unclaimed results inside the post-reset window belong to ops issued
  // before reset and are discarded without flagging.
  assign res_bad    = bus.i_add_valid && (inflight_q == '0) && (guard_q == '0);

  always_comb begin
    state_d     = state_q;
    h_full_d    = h_full_q;
    h_data_d    = h_data_q;
    add_valid_d = 1'b0;
    add_data1_d = add_data1_q;
    add_data2_d = add_data2_q;
    sum_valid_d = 1'b0;
    sum_d       = sum_q;
    busy_d      = busy_q;
    err_d       = err_q | res_bad;
    issue       = 1'b0;
    pop         = 1'b0;

    // Pairing priority: partial sums are consumed before new elements so the
    // FIFO drains; in DRAIN take_x is always 0, leaving only the H/P pairings.
    if (h_full_q && p_nonempty) begin
      issue       = 1'b1;
      add_data1_d = h_data_q;
      add_data2_d = p_head;
      pop         = 1'b1;
      h_full_d    = 1'b0;
    end else if (h_full_q && take_x) begin
      issue       = 1'b1;
      add_data1_d = h_data_q;
      add_data2_d = bus.i_data;
      h_full_d    = 1'b0;
    end else if (p_nonempty && take_x) begin
      issue       = 1'b1;
      add_data1_d = p_head;
      add_data2_d = bus.i_data;
      pop         = 1'b1;
    end else if (p_nonempty) begin
      h_data_d    = p_head;
      h_full_d    = 1'b1;
      pop         = 1'b1;
    end else if (!h_full_q && take_x) begin
      h_data_d    = bus.i_data;
      h_full_d    = 1'b1;
    end else if ((state_q == ST_DRAIN) && h_full_q && (inflight_q == '0)) begin
      // Only one value left and nothing in the adder: that value is the sum.
      sum_d       = h_data_q;
      sum_valid_d = 1'b1;
      h_full_d    = 1'b0;
      busy_d      = 1'b0;
      state_d     = ST_ACCUM;
    end

    add_valid_d = issue;
    if (take_x) begin
      busy_d = 1'b1;
      if (bus.i_data_last) state_d = ST_DRAIN;
    end
  end

  assign inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(res_take);
  assign p_count_d  = p_count_q + CNT_W'(res_take) - CNT_W'(pop);
  assign wr_ptr_d   = res_take ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  assign guard_d    = (guard_q != '0) ? guard_q - GRD_W'(1) : guard_q;

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q     <= ST_ACCUM;
      h_full_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      p_count_q   <= '0;
      inflight_q  <= '0;
      guard_q     <= GRD_W'(ADD_LATENCY);
      add_valid_q <= 1'b0;
      add_data1_q <= '0;
      add_data2_q <= '0;
      sum_valid_q <= 1'b0;
      sum_q       <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_full_q    <= h_full_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      p_count_q   <= p_count_d;
      inflight_q  <= inflight_d;
      guard_q     <= guard_d;
      add_valid_q <= add_valid_d;
      add_data1_q <= add_data1_d;
      add_data2_q <= add_data2_d;
      sum_valid_q <= sum_valid_d;
      sum_q       <= sum_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // Data storage carries no reset; validity is tracked by h_full_q / p_count_q.
  always_ff @(posedge s_clk) begin
    h_data_q <= h_data_d;
    if (res_take) fifo_mem_q[wr_ptr_q] <= bus.i_add_data;
  end

  assign bus.i_data_ready = ready;
  assign bus.o_add_valid  = add_valid_q;
  assign bus.o_add_data1  = add_data1_q;
  assign bus.o_add_data2  = add_data2_q;
  assign bus.o_sum_valid  = sum_valid_q;
  assign bus.o_sum        = sum_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_err        = err_q;

endmodule

// File: tb/tb_fp32_sum_reducer.sv
module tb_fp32_sum_reducer;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp32_sum_reducer_if if1();
  fp32_sum_reducer_if if2();

  fp32_sum_reducer #(.ADD_LATENCY(LAT), .FIFO_DEPTH(8)) dut1 (.s_clk(clk), .s_rst(rst), .bus(if1));
  fp32_sum_reducer #(.ADD_LATENCY(LAT), .FIFO_DEPTH(2)) dut2 (.s_clk(clk), .s_rst(rst), .bus(if2));

  int checks = 0;
  int failures = 0;

  // fp32 <-> real for normal/zero values, via the double bit layout
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // behavioural adders, latency LAT, plus an injection port on adder 1
  logic        av1 [LAT];
  logic [31:0] ad1 [LAT];
  logic        av2 [LAT];
  logic [31:0] ad2 [LAT];
  logic        inj_v = 1'b0;
  logic [31:0] inj_d = 32'd0;

  always @(posedge clk) begin
    av1[0] <= if1.o_add_valid;
    ad1[0] <= if1.o_add_valid ? r2f(f2r(if1.o_add_data1) + f2r(if1.o_add_data2)) : 32'd0;
    av2[0] <= if2.o_add_valid;
    ad2[0] <= if2.o_add_valid ? r2f(f2r(if2.o_add_data1) + f2r(if2.o_add_data2)) : 32'd0;
    for (int i = 1; i < LAT; i++) begin
      av1[i] <= av1[i-1];
      ad1[i] <= ad1[i-1];
      av2[i] <= av2[i-1];
      ad2[i] <= ad2[i-1];
    end
  end

  assign if1.i_add_valid = av1[LAT-1] | inj_v;
  assign if1.i_add_data  = inj_v ? inj_d : ad1[LAT-1];
  assign if2.i_add_valid = av2[LAT-1];
  assign if2.i_add_data  = ad2[LAT-1];

  // monitors
  int iss_cnt = 0, sum_cnt = 0, iss_cnt2 = 0, sum_cnt2 = 0, wide = 0;
  logic [31:0] last_sum = 32'd0, last_sum2 = 32'd0;
  logic [63:0] iss_log[$];
  logic prev_sv = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (if1.o_add_valid) begin
        iss_cnt = iss_cnt + 1;
        iss_log.push_back({if1.o_add_data1, if1.o_add_data2});
      end
      if (if1.o_sum_valid) begin
        sum_cnt = sum_cnt + 1;
        last_sum = if1.o_sum;
        if (prev_sv) wide = wide + 1;
      end
      prev_sv = if1.o_sum_valid;
      if (if2.o_add_valid) iss_cnt2 = iss_cnt2 + 1;
      if (if2.o_sum_valid) begin
        sum_cnt2 = sum_cnt2 + 1;
        last_sum2 = if2.o_sum;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    if1.i_data_valid = 1'b1;
    if1.i_data       = d;
    if1.i_data_last  = l;
    while (!if1.i_data_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle();
    if1.i_data_valid = 1'b0;
    if1.i_data_last  = 1'b0;
  endtask

  task automatic wait_sum(input int target);
    int n = 0;
    while (sum_cnt < target && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sum_cnt < target) chk("sum_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [3:0][31:0] e;
    int               n;
    logic [31:0]      sum;
    int               issues;
    logic [31:0]      d1;
    logic [31:0]      d2;
  } vec_t;

  vec_t tbl[4];
  int ib, sb, acc, n2;
  logic saw_low;

  initial begin
    tbl[0].n = 1; tbl[0].e[0] = 32'h3FC00000;
    tbl[0].sum = 32'h3FC00000; tbl[0].issues = 0; tbl[0].d1 = 32'h0; tbl[0].d2 = 32'h0;
    tbl[1].n = 2; tbl[1].e[0] = 32'h3FE00000; tbl[1].e[1] = 32'h40280000;
    tbl[1].sum = 32'h408C0000; tbl[1].issues = 1; tbl[1].d1 = 32'h3FE00000; tbl[1].d2 = 32'h40280000;
    tbl[2].n = 4; tbl[2].e[0] = 32'h3F800000; tbl[2].e[1] = 32'h40000000;
    tbl[2].e[2] = 32'h40400000; tbl[2].e[3] = 32'h40800000;
    tbl[2].sum = 32'h41200000; tbl[2].issues = 3; tbl[2].d1 = 32'h3F800000; tbl[2].d2 = 32'h40000000;
    tbl[3].n = 3; tbl[3].e[0] = 32'h40A00000; tbl[3].e[1] = 32'h3F000000; tbl[3].e[2] = 32'h40C00000;
    tbl[3].sum = 32'h41380000; tbl[3].issues = 2; tbl[3].d1 = 32'h40A00000; tbl[3].d2 = 32'h3F000000;

    if1.i_data_valid = 1'b0; if1.i_data = 32'd0; if1.i_data_last = 1'b0;
    if2.i_data_valid = 1'b0; if2.i_data = 32'd0; if2.i_data_last = 1'b0;

    repeat (8) @(negedge clk);
    chk("rst_add_valid", {31'd0, if1.o_add_valid}, 32'd0);
    chk("rst_add_data1", if1.o_add_data1, 32'd0);
    chk("rst_sum_valid", {31'd0, if1.o_sum_valid}, 32'd0);
    chk("rst_sum", if1.o_sum, 32'd0);
    chk("rst_busy", {31'd0, if1.o_busy}, 32'd0);
    chk("rst_err", {31'd0, if1.o_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, if1.i_data_ready}, 32'd1);

    // single element: pulse after the edge following the accepting edge
    send(32'h3FC00000, 1'b1);
    idle();
    chk("single_no_pulse_yet", {31'd0, if1.o_sum_valid}, 32'd0);
    @(negedge clk);
    chk("single_pulse", {31'd0, if1.o_sum_valid}, 32'd1);
    chk("single_sum", if1.o_sum, 32'h3FC00000);
    @(negedge clk);
    chk("single_pulse_end", {31'd0, if1.o_sum_valid}, 32'd0);
    chk("single_no_issue", iss_cnt, 32'd0);
    repeat (3) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      #1;
      ib = iss_cnt;
      sb = sum_cnt;
      for (int k = 0; k < tbl[v].n; k++) begin
        send(tbl[v].e[k], k == tbl[v].n - 1);
        if (k == 0) chk($sformatf("v%0d_busy_set", v), {31'd0, if1.o_busy}, 32'd1);
      end
      idle();
      wait_sum(sb + 1);
      chk($sformatf("v%0d_sum", v), last_sum, tbl[v].sum);
      chk($sformatf("v%0d_issues", v), iss_cnt - ib, tbl[v].issues);
      if (tbl[v].issues > 0 && iss_log.size() > ib) begin
        chk($sformatf("v%0d_first_d1", v), iss_log[ib][63:32], tbl[v].d1);
        chk($sformatf("v%0d_first_d2", v), iss_log[ib][31:0], tbl[v].d2);
      end
      chk($sformatf("v%0d_busy_clear", v), {31'd0, if1.o_busy}, 32'd0);
      chk($sformatf("v%0d_err", v), {31'd0, if1.o_err}, 32'd0);
      repeat (3) @(negedge clk);
    end

    // FIFO_DEPTH=2 instance: 16 ones with valid held high
    acc = 0; n2 = 0; saw_low = 1'b0;
    if2.i_data_valid = 1'b1; if2.i_data = 32'h3F800000; if2.i_data_last = 1'b0;
    while (acc < 16 && n2 < 2000) begin
      if2.i_data_last = (acc == 15);
      if (if2.i_data_ready) acc++;
      else saw_low = 1'b1;
      @(negedge clk);
      n2++;
    end
    if2.i_data_valid = 1'b0; if2.i_data_last = 1'b0;
    chk("d2_accepted", acc, 32'd16);
    chk("d2_ready_dropped", {31'd0, saw_low}, 32'd1);
    n2 = 0;
    while (sum_cnt2 < 1 && n2 < 500) begin
      @(negedge clk);
      #1;
      n2++;
    end
    chk("d2_sum_count", sum_cnt2, 32'd1);
    chk("d2_sum", last_sum2, 32'h41800000);
    chk("d2_issues", iss_cnt2, 32'd15);
    chk("d2_err", {31'd0, if2.o_err}, 32'd0);

    // reset mid-vector with an op still inside the adder
    sb = sum_cnt;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    send(32'h40400000, 1'b0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_add_valid", {31'd0, if1.o_add_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, if1.o_busy}, 32'd0);
    chk("mid_rst_sum_valid", {31'd0, if1.o_sum_valid}, 32'd0);
    chk("mid_rst_err", {31'd0, if1.o_err}, 32'd0);
    repeat (10) @(negedge clk);
    #1;
    chk("stale_err", {31'd0, if1.o_err}, 32'd0);
    chk("stale_no_sum", sum_cnt, sb);
    sb = sum_cnt;
    send(32'h40000000, 1'b0);
    send(32'h40400000, 1'b1);
    idle();
    wait_sum(sb + 1);
    chk("post_rst_sum", last_sum, 32'h40A00000);
    repeat (10) @(negedge clk);

    // unexpected result while idle
    chk("pre_inject_err", {31'd0, if1.o_err}, 32'd0);
    inj_v = 1'b1; inj_d = 32'h3F800000;
    @(negedge clk);
    inj_v = 1'b0;
    chk("inject_err", {31'd0, if1.o_err}, 32'd1);
    #1;
    sb = sum_cnt;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b1);
    idle();
    wait_sum(sb + 1);
    chk("after_err_sum", last_sum, 32'h40400000);
    chk("err_sticky", {31'd0, if1.o_err}, 32'd1);
    chk("sum_pulse_width", wide, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule
